// File: rtl/ifexp_arbiter_if.sv
// Request/response bundle for ifexp_arbiter.
// The slave side is the arbiter; the master side is clients plus consumer.
interface ifexp_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREQ*W-1:0] REQ_A;
  logic [NREQ*W-1:0] REQ_B;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [W-1:0]      RSP_DATA;
  logic [IDW-1:0]    RSP_ID;

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ID
  );

  modport master (
    output REQ_VALID, REQ_A, REQ_B, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ID
  );
endinterface

// File: rtl/ifexp_arbiter.sv
// Round-robin arbiter sharing one compare-select unit (A>B ? A : B+1).
// Optional grant counter built when IFEXP_ARB_STATS_EN is defined.
module ifexp_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  ifexp_arbiter_if.slave      bus,
  output logic [15:0]         STAT_GRANTS
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, gnt_id;
  logic [W-1:0]   data_q, data_d;
  logic [W-1:0]   a_g, b_g;
  logic [IDW:0]   idx;
  logic           found;
  logic           slot_free;
  logic           grant;

  // First valid requester at or after ptr, wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (!found && bus.REQ_VALID[idx[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
  end

  assign slot_free = (state_q == EMPTY) || bus.RSP_READY;
  assign grant     = RST_N && slot_free && found;

  assign a_g    = bus.REQ_A[gnt_id*W +: W];
  assign b_g    = bus.REQ_B[gnt_id*W +: W];
  assign data_d = (a_g > b_g) ? a_g : b_g + W'(1);
  assign ptr_d  = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL: begin
        if (grant)              state_d = FULL;
        else if (bus.RSP_READY) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    bus.REQ_READY = '0;
    if (grant)
      bus.REQ_READY = NREQ'(1) << gnt_id;
    bus.RSP_VALID = (state_q == FULL);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q  <= '0;
      id_q   <= '0;
      data_q <= '0;
    end else if (grant) begin
      ptr_q  <= ptr_d;
      id_q   <= gnt_id;
      data_q <= data_d;
    end
  end

  assign bus.RSP_DATA = data_q;
  assign bus.RSP_ID   = id_q;

`ifdef IFEXP_ARB_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (grant && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign STAT_GRANTS = cnt_q;
`else
  assign STAT_GRANTS = '0;
`endif
endmodule

// File: tb/tb_ifexp_arbiter.sv
// Directed bench for ifexp_arbiter with a per-cycle reference model.
// Expected grant count follows IFEXP_ARB_STATS_EN.
module tb_ifexp_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic        CLK;
  logic        RST_N;
  logic [15:0] STAT_GRANTS;

  ifexp_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  ifexp_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus),
    .STAT_GRANTS (STAT_GRANTS)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot contents, pointer and grant count.
  int          m_ptr;
  bit          m_full;
  int          m_data;
  int          m_id;
  int          m_cnt;

  function automatic int winner(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (p + i) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int exp_grant();
    if (m_full && !bus.RSP_READY) return -1;
    return winner(bus.REQ_VALID, m_ptr);
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_ptr = 0; m_full = 0; m_data = 0; m_id = 0; m_cnt = 0;
    end else begin
      int g, a, b;
      g = exp_grant();
      if (g >= 0) begin
        a = int'(bus.REQ_A[g*W +: W]);
        b = int'(bus.REQ_B[g*W +: W]);
        m_data = (a > b) ? a : (b + 1) % 256;
        m_id   = g;
        m_full = 1;
        m_ptr  = (g + 1) % NREQ;
`ifdef IFEXP_ARB_STATS_EN
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
      end else if (m_full && bus.RSP_READY) begin
        m_full = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      int g;
      logic [NREQ-1:0] er;
      g  = exp_grant();
      er = (g >= 0) ? (NREQ'(1) << g) : '0;
      chk("model_req_ready", 32'(bus.REQ_READY), 32'(er));
      chk("model_rsp_valid", 32'(bus.RSP_VALID), 32'(m_full));
      if (m_full) begin
        chk("model_rsp_data", 32'(bus.RSP_DATA), m_data);
        chk("model_rsp_id", 32'(bus.RSP_ID), m_id);
      end
      chk("model_stat", 32'(STAT_GRANTS), m_cnt);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a,
                         input logic [7:0] b);
    bus.REQ_A[i*W +: W] = a;
    bus.REQ_B[i*W +: W] = b;
  endtask

  task automatic one(input int i, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp, input string name);
    set_req(i, a, b);
    bus.REQ_VALID = NREQ'(1) << i;
    step();
    bus.REQ_VALID = '0;
    #2;
    chk({name, "_valid"}, 32'(bus.RSP_VALID), 1);
    chk(name, 32'(bus.RSP_DATA), 32'(exp));
    chk({name, "_id"}, 32'(bus.RSP_ID), i);
  endtask

  int rr_ids [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N         = 1'b0;
    bus.REQ_VALID = '1;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.RSP_READY = 1'b1;
    #12;
    chk("rst_req_ready", 32'(bus.REQ_READY), 0);
    chk("rst_rsp_valid", 32'(bus.RSP_VALID), 0);
    chk("rst_rsp_data", 32'(bus.RSP_DATA), 0);
    chk("rst_rsp_id", 32'(bus.RSP_ID), 0);
    chk("rst_stat", 32'(STAT_GRANTS), 0);
    bus.REQ_VALID = '0;
    step();
    RST_N = 1'b1;
    step();

    // Single request from requester 2.
    set_req(2, 8'h10, 8'h05);
    bus.REQ_VALID = 4'b0100;
    #2;
    chk("single_ready", 32'(bus.REQ_READY), 32'b0100);
    step();
    bus.REQ_VALID = '0;
    #2;
    chk("single_valid", 32'(bus.RSP_VALID), 1);
    chk("single_data", 32'(bus.RSP_DATA), 32'h10);
    chk("single_id", 32'(bus.RSP_ID), 2);

    one(0, 8'h05, 8'h05, 8'h06, "tie");
    one(1, 8'h00, 8'hFF, 8'h00, "wrap");
    one(3, 8'hFF, 8'hFE, 8'hFF, "amax");
    one(2, 8'h7F, 8'h80, 8'h81, "unsigned");

    // Round robin from a fresh pointer.
    step();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 8'(8'h20 + i), 8'(i));
    bus.REQ_VALID = '1;
    for (int k = 0; k < 6; k++) begin
      step();
      #2;
      chk("rr_valid", 32'(bus.RSP_VALID), 1);
      chk("rr_id", 32'(bus.RSP_ID), rr_ids[k]);
    end

    // Backpressure with the slot holding 0x42 from requester 1.
    bus.REQ_VALID = '0;
    step();
    set_req(1, 8'h42, 8'h00);
    bus.REQ_VALID = 4'b0010;
    step();
    bus.RSP_READY = 1'b0;
    bus.REQ_VALID = '1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("bp_ready", 32'(bus.REQ_READY), 0);
      chk("bp_data", 32'(bus.RSP_DATA), 32'h42);
      chk("bp_valid", 32'(bus.RSP_VALID), 1);
      step();
    end
    bus.RSP_READY = 1'b1;
    #2;
    chk("bp_refill_ready", 32'(bus.REQ_READY), 32'b0100);
    step();
    #2;
    chk("bp_refill_valid", 32'(bus.RSP_VALID), 1);
    chk("bp_refill_id", 32'(bus.RSP_ID), 2);
    chk("bp_refill_data", 32'(bus.RSP_DATA), 32'h22);

    // Reset while full.
    RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.RSP_VALID), 0);
    chk("mid_rst_data", 32'(bus.RSP_DATA), 0);
    chk("mid_rst_id", 32'(bus.RSP_ID), 0);
    chk("mid_rst_ready", 32'(bus.REQ_READY), 0);
    step();
    RST_N = 1'b1;
    bus.REQ_VALID = 4'b1010;
    #2;
    chk("post_rst_ready", 32'(bus.REQ_READY), 32'b0010);
    step();
    #2;
    chk("post_rst_id", 32'(bus.RSP_ID), 1);
    chk("post_rst_valid", 32'(bus.RSP_VALID), 1);

    // Long grant run for the counter.
    bus.REQ_VALID = '1;
    repeat (65540) step();
    #2;
`ifdef IFEXP_ARB_STATS_EN
    chk("stat_sat", 32'(STAT_GRANTS), 32'hFFFF);
`else
    chk("stat_off", 32'(STAT_GRANTS), 0);
`endif
    bus.REQ_VALID = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
